// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if: FIFO, baud and TX-pin signals of the UART transmitter (PARITY_EN adds PARITY_ODD)
interface uart_tx_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W = 8
);
  logic              EN;
  logic [DIV_W-1:0]  DIVISOR;
  logic              FIFO_EMPTY;
  logic [DATA_W-1:0] FIFO_DATA;
`ifdef PARITY_EN
  logic              PARITY_ODD;
`endif
  logic              FIFO_POP;
  logic              TX;
  logic              BUSY;
  logic              DONE;
  logic              TXE_IRQ;
  modport master (
`ifdef PARITY_EN
    input  PARITY_ODD,
`endif
    input  EN, DIVISOR, FIFO_EMPTY, FIFO_DATA,
    output FIFO_POP, TX, BUSY, DONE, TXE_IRQ
  );
  modport slave (
`ifdef PARITY_EN
    output PARITY_ODD,
`endif
    output EN, DIVISOR, FIFO_EMPTY, FIFO_DATA,
    input  FIFO_POP, TX, BUSY, DONE, TXE_IRQ
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: pops FIFO bytes and serialises 8N1 frames on TX; define PARITY_EN for a parity bit
module uart_tx_sequencer #(
  parameter int DATA_W = 8,
  parameter int DIV_W = 8,
  parameter int STOP_BITS = 1
) (
  input logic CLK,
  input logic NRST,
  uart_tx_sequencer_if.master bus
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t            st, st_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [DIV_W-1:0]  div_q, div_n;
  logic [DIV_W-1:0]  timer, timer_n;
  logic [IW-1:0]     idx, idx_n;
  logic              stop_cnt, stop_n;
  logic              tx, tx_n;
  logic              bit_end, last_stop, pop;
`ifdef PARITY_EN
  logic              par, par_n;
`endif
  assign bit_end = timer == '0;
  assign last_stop = st == STOP && bit_end && stop_cnt == 1'(STOP_BITS - 1);
  assign pop = NRST && bus.EN && !bus.FIFO_EMPTY && (st == IDLE || last_stop);
  // state register: reset aborts any frame and forces the line idle
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      st <= IDLE;
      sh <= '0;
      div_q <= '0;
      timer <= '0;
      idx <= '0;
      stop_cnt <= 1'b0;
      tx <= 1'b1;
`ifdef PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      st <= st_n;
      sh <= sh_n;
      div_q <= div_n;
      timer <= timer_n;
      idx <= idx_n;
      stop_cnt <= stop_n;
      tx <= tx_n;
`ifdef PARITY_EN
      par <= par_n;
`endif
    end
  end
  // next state: bit sequencing, with a pop overriding everything to start a new frame
  always_comb begin
    st_n = st;
    sh_n = sh;
    div_n = div_q;
    timer_n = st == IDLE ? '0 : bit_end ? div_q : timer - DIV_W'(1);
    idx_n = idx;
    stop_n = stop_cnt;
`ifdef PARITY_EN
    par_n = par;
`endif
    unique case (st)
      IDLE: st_n = IDLE;
      START: begin
        if (bit_end) begin
          st_n = DATA;
          idx_n = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_n = sh >> 1;
          idx_n = idx + 1'b1;
          if (idx == IW'(DATA_W - 1)) begin
`ifdef PARITY_EN
            st_n = PARITY;
`else
            st_n = STOP;
`endif
            stop_n = 1'b0;
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) begin
          st_n = STOP;
          stop_n = 1'b0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          stop_n = stop_cnt + 1'b1;
          st_n = stop_cnt == 1'(STOP_BITS - 1) ? IDLE : STOP;
        end
      end
      default: st_n = IDLE;
    endcase
    if (pop) begin
      st_n = START;
      sh_n = bus.FIFO_DATA;
      div_n = bus.DIVISOR;
      timer_n = bus.DIVISOR;
`ifdef PARITY_EN
      par_n = ^bus.FIFO_DATA ^ bus.PARITY_ODD;
`endif
    end
`ifdef PARITY_EN
    tx_n = st_n == START ? 1'b0 : st_n == DATA ? sh_n[0] : st_n == PARITY ? par_n : 1'b1;
`else
    tx_n = st_n == START ? 1'b0 : st_n == DATA ? sh_n[0] : 1'b1;
`endif
  end
  // outputs: status flags decoded from the current state
  always_comb begin
    bus.FIFO_POP = pop;
    bus.TX = tx;
    bus.BUSY = st != IDLE;
    bus.DONE = last_stop;
    bus.TXE_IRQ = bus.EN && st == IDLE && bus.FIFO_EMPTY;
  end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: scoreboard bench decoding TX frames against the bytes fed to the FIFO
module tb_uart_tx_sequencer;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk, nrst;
  uart_tx_sequencer_if #(.DATA_W(8), .DIV_W(8)) bus ();
  uart_tx_sequencer dut (.CLK(clk), .NRST(nrst), .bus(bus.master));
  logic [7:0] fmem [0:15];
  int wr, rd;
  logic [7:0] exp_q [$];
  int n_chk, n_fail;
  int n_pop, n_busy, n_done, done_at, pop_done, irq_bad;
  logic s_tx, s_busy, s_pop, s_done, s_irq, s_nrst;
  logic txlog [0:63];
  logic [11:0] fbits;
  logic dec_on;
  int dcnt, cur_div;
  logic par_odd;
  assign bus.FIFO_EMPTY = wr == rd;
  assign bus.FIFO_DATA = fmem[rd[3:0]];
`ifdef PARITY_EN
  assign bus.PARITY_ODD = par_odd;
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [NB-1:0] fr(input logic [7:0] b);
`ifdef PARITY_EN
    return {1'b1, ^b ^ par_odd, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction
  task automatic send(input logic [7:0] b);
    fmem[wr[3:0]] = b;
    wr++;
    exp_q.push_back(b);
  endtask
  task automatic clr();
    n_pop = 0;
    n_busy = 0;
    n_done = 0;
    done_at = 0;
    pop_done = 0;
    irq_bad = 0;
  endtask
  task automatic decode();
    int d1;
    logic [7:0] exp_b;
    d1 = cur_div + 1;
    if (!s_nrst) begin
      if (dec_on && exp_q.size() > 0) void'(exp_q.pop_front());
      dec_on = 1'b0;
      return;
    end
    if (!dec_on && !s_tx) begin
      dec_on = 1'b1;
      dcnt = 0;
    end
    if (dec_on) begin
      if (dcnt % d1 == cur_div / 2) begin
        fbits[dcnt / d1] = s_tx;
        if (dcnt / d1 == NB - 1) begin
          dec_on = 1'b0;
          chk("sb_nonempty", exp_q.size() > 0, 1);
          exp_b = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
          chk("frame_data", fbits[8:1], exp_b);
          chk("frame_start", fbits[0], 0);
          chk("frame_stop", fbits[NB-1], 1);
`ifdef PARITY_EN
          chk("frame_par", fbits[9], ^exp_b ^ par_odd);
`endif
        end
      end
      dcnt++;
    end
  endtask
  task automatic step();
    @(negedge clk);
    s_tx = bus.TX;
    s_busy = bus.BUSY;
    s_pop = bus.FIFO_POP;
    s_done = bus.DONE;
    s_irq = bus.TXE_IRQ;
    s_nrst = nrst;
    if (s_pop === 1'b1) n_pop++;
    if (s_busy === 1'b1) begin
      if (n_busy < 64) txlog[n_busy] = s_tx;
      n_busy++;
    end
    if (s_done === 1'b1) begin
      n_done++;
      done_at = n_busy;
    end
    if (s_pop === 1'b1 && s_done === 1'b1) pop_done++;
    if (s_irq !== (bus.EN & ~s_busy & bus.FIFO_EMPTY)) irq_bad++;
    decode();
    @(posedge clk);
    #1;
    if (s_pop === 1'b1) rd++;
  endtask
  task automatic run_until_idle(input string tag, input int lim);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (n_busy > 0 && !s_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask
  task automatic run_until_busy(input string tag, input int n, input int lim);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (n_busy == n) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask
  initial begin
    logic [NB-1:0] ef;
    logic [31:0] v;
    logic [3:0] g;
    n_chk = 0;
    n_fail = 0;
    wr = 0;
    rd = 0;
    dec_on = 1'b0;
    dcnt = 0;
    par_odd = 1'b0;
    for (int i = 0; i < 16; i++) fmem[i] = 8'h00;
    nrst = 1'b0;
    bus.EN = 1'b1;
    bus.DIVISOR = 8'd0;
    cur_div = 0;
    clr();
    step();
    step();
    nrst = 1'b1;
    clr();
    step();
    chk("rst_tx", s_tx, 1);
    chk("rst_busy", s_busy, 0);
    chk("rst_pop", s_pop, 0);
    chk("rst_done", s_done, 0);
    chk("rst_irq", s_irq, 1);
    bus.DIVISOR = 8'd3;
    cur_div = 3;
    clr();
    send(8'hA5);
    run_until_busy("t2_mid", 10, 100);
    bus.DIVISOR = 8'd0;
    run_until_idle("t2_end", 200);
    chk("t2_pops", n_pop, 1);
    chk("t2_busy", n_busy, NB * 4);
    chk("t2_done", n_done, 1);
    chk("t2_done_at", done_at, NB * 4);
    ef = fr(8'hA5);
    for (int b = 0; b < NB; b++) begin
      g = {txlog[4*b+3], txlog[4*b+2], txlog[4*b+1], txlog[4*b]};
      chk("t2_bit", g, {4{ef[b]}});
    end
    step();
    chk("t2_irq_idle", s_irq, 1);
    chk("t2_irq_model", irq_bad, 0);
    bus.DIVISOR = 8'd0;
    cur_div = 0;
    clr();
    send(8'h00);
    send(8'hFF);
    run_until_idle("t3_end", 100);
    chk("t3_pops", n_pop, 2);
    chk("t3_pop_in_done", pop_done, 1);
    chk("t3_busy", n_busy, 2 * NB);
    chk("t3_done", n_done, 2);
    v = '0;
    for (int i = 0; i < 2 * NB; i++) v[i] = txlog[i];
    chk("t3_tx", v, {fr(8'hFF), fr(8'h00)});
    chk("t3_irq_model", irq_bad, 0);
    bus.DIVISOR = 8'd3;
    cur_div = 3;
    clr();
    send(8'h3C);
    send(8'h5A);
    run_until_busy("t4_mid", 14, 100);
    bus.EN = 1'b0;
    run_until_idle("t4_end", 200);
    for (int i = 0; i < 5; i++) step();
    chk("t4_pops", n_pop, 1);
    chk("t4_busy", n_busy, NB * 4);
    chk("t4_done", n_done, 1);
    chk("t4_irq", s_irq, 0);
    chk("t4_irq_model", irq_bad, 0);
    chk("t4_left", exp_q.size(), 1);
    rd = wr;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    bus.EN = 1'b1;
    bus.DIVISOR = 8'd1;
    cur_div = 1;
    clr();
    send(8'h96);
    send(8'h69);
    run_until_busy("t5_mid", 8, 100);
    nrst = 1'b0;
    step();
    chk("t5_pop_in_rst", s_pop, 0);
    nrst = 1'b1;
    step();
    chk("t5_tx", s_tx, 1);
    chk("t5_busy", s_busy, 0);
    chk("t5_pop", s_pop, 1);
    run_until_idle("t5_end", 200);
    chk("t5_pops", n_pop, 2);
    chk("t5_irq_model", irq_bad, 0);
`ifdef PARITY_EN
    par_odd = 1'b0;
    bus.DIVISOR = 8'd1;
    cur_div = 1;
    clr();
    send(8'h07);
    run_until_idle("t6_end", 200);
    chk("t6_busy", n_busy, 22);
    chk("t6_par", {txlog[19], txlog[18]}, 2'b11);
`endif
    step();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
